// File: rtl/ram_wait_ctrl.sv
// ram_wait_ctrl
//   Multi-cycle data RAM model plus its access controller. It sits directly
//   below the data cache and owns the RAM_REGISTER_COUNT x DATA_WIDTH word array.
//   Writes are posted in one cycle. Reads take READ_LATENCY cycles and finish
//   with a single-cycle ram_ready pulse. This lets the cache stall path run
//   against a realistically slow memory.
//
// Parameters
//   DATA_WIDTH          word width
//   RAM_REGISTER_COUNT  words in the array (power of two)
//   READ_LATENCY        cycles from read acceptance to ram_ready (1..15)
//
// Ports
//   clk            in   rising-edge clock
//   resetN         in   asynchronous active-low reset
//   ram_out_m      in   write data from the cache
//   ram_write_m    in   write strobe (accepted in every state)
//   ram_read_m     in   read request level, held until ram_ready
//   ram_data_addr  in   word address for reads and writes
//   ram_in_m       out  registered read data; holds until the next read completes
//   ram_ready      out  one-cycle pulse, ram_in_m valid for the accepted read
//   ram_busy       out  high whenever the controller is not idle
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for ram_read_m; reads are accepted only here
// READ_WAIT | latency countdown, request address frozen in addr_q
// READ_DONE | ram_in_m valid, ram_ready high for exactly this cycle

module ram_wait_ctrl #(
    parameter int DATA_WIDTH         = 16,
    parameter int RAM_REGISTER_COUNT = 1024,
    parameter int READ_LATENCY       = 3,
    localparam int ADDR_BITS         = $clog2(RAM_REGISTER_COUNT)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [DATA_WIDTH-1:0] ram_out_m,
    input  logic                  ram_write_m,
    input  logic                  ram_read_m,
    input  logic [ADDR_BITS-1:0]  ram_data_addr,
    output logic [DATA_WIDTH-1:0] ram_in_m,
    output logic                  ram_ready,
    output logic                  ram_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        READ_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);
    localparam bit         LAT_ONE  = (READ_LATENCY == 1);

    logic [DATA_WIDTH-1:0] mem [0:RAM_REGISTER_COUNT-1];

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [ADDR_BITS-1:0]  addr_nxt;
    logic [ADDR_BITS-1:0]  rd_addr;
    logic                  load_data;

    // Next-state logic. Requests seen outside IDLE are ignored, so a requester
    // still holding ram_read_m during READ_DONE does not start a second read.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        case (state)
            IDLE: begin
                if (ram_read_m) begin
                    addr_nxt  = ram_data_addr;
                    cnt_nxt   = LAT_LOAD;
                    state_nxt = LAT_ONE ? READ_DONE : READ_WAIT;
                end
            end
            READ_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = READ_DONE;
                end
            end
            READ_DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The array is sampled on the edge that enters READ_DONE. With a latency
    // of one that edge is also the accept edge, so the live address is used
    // because addr_q has not been loaded yet.
    assign load_data = (state_nxt == READ_DONE) && (state != READ_DONE);
    assign rd_addr   = (state == IDLE) ? ram_data_addr : addr_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_q   <= '0;
            ram_in_m <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
            if (load_data) begin
                ram_in_m <= mem[rd_addr];
            end
        end
    end

    // The array is deliberately left unreset. A write on the same edge as the
    // READ_DONE load is not visible to that read (read-before-write).
    always_ff @(posedge clk) begin
        if (ram_write_m) begin
            mem[ram_data_addr] <= ram_out_m;
        end
    end

    assign ram_ready = (state == READ_DONE);
    assign ram_busy  = (state != IDLE);

endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Testbench for ram_wait_ctrl. It uses two instances: dut0 with the default
// latency of 3 and dut1 with a latency of 1. Expected read data is queued when
// a read is issued. Per-instance monitors pop the queue on every ram_ready and
// compare the data.

module tb_ram_wait_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;

    logic [15:0] dout0 = '0;
    logic        wr0 = 1'b0;
    logic        rd0 = 1'b0;
    logic [9:0]  addr0 = '0;
    logic [15:0] din0;
    logic        rdy0;
    logic        busy0;

    logic [15:0] dout1 = '0;
    logic        wr1 = 1'b0;
    logic        rd1 = 1'b0;
    logic [9:0]  addr1 = '0;
    logic [15:0] din1;
    logic        rdy1;
    logic        busy1;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    always #5 clk = ~clk;

    ram_wait_ctrl dut0 (
        .clk           (clk),
        .resetN        (resetN),
        .ram_out_m     (dout0),
        .ram_write_m   (wr0),
        .ram_read_m    (rd0),
        .ram_data_addr (addr0),
        .ram_in_m      (din0),
        .ram_ready     (rdy0),
        .ram_busy      (busy0)
    );

    ram_wait_ctrl #(.READ_LATENCY(1)) dut1 (
        .clk           (clk),
        .resetN        (resetN),
        .ram_out_m     (dout1),
        .ram_write_m   (wr1),
        .ram_read_m    (rd1),
        .ram_data_addr (addr1),
        .ram_in_m      (din1),
        .ram_ready     (rdy1),
        .ram_busy      (busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rdy0) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_data0: unexpected ram_ready with data %0h, none expected", din0);
            end else begin
                check("rd_data0", {16'h0, din0}, {16'h0, q0.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rdy1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_data1: unexpected ram_ready with data %0h, none expected", din1);
            end else begin
                check("rd_data1", {16'h0, din1}, {16'h0, q1.pop_front()});
            end
        end
    end

    task automatic write0(input logic [9:0] a, input logic [15:0] d);
        @(negedge clk);
        wr0   = 1'b1;
        addr0 = a;
        dout0 = d;
        @(negedge clk);
        wr0 = 1'b0;
    endtask

    // Called at a negedge, "start" cycles after the read was issued. It waits
    // for ram_ready and checks the latency and the busy cycles. It then drops
    // the request and checks that the pulse was a single cycle.
    task automatic wait_ready0(input int start, input int exp_lat, input string name);
        int c = start;
        int b = 0;
        while (!rdy0 && c < 20) begin
            @(negedge clk);
            c++;
            if (busy0) b++;
        end
        check({name, "_lat"}, c, exp_lat);
        check({name, "_busy_cycles"}, b, exp_lat - start);
        rd0 = 1'b0;
        @(negedge clk);
        check({name, "_ready_pulse"}, {31'h0, rdy0}, 32'h0);
        check({name, "_busy_idle"}, {31'h0, busy0}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("rst_ready", {31'h0, rdy0}, 32'h0);
        check("rst_busy", {31'h0, busy0}, 32'h0);
        check("rst_data", {16'h0, din0}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;

        // Write 1234 @5, then a latency-3 read
        write0(10'd5, 16'h1234);
        rd0   = 1'b1;
        addr0 = 10'd5;
        q0.push_back(16'h1234);
        wait_ready0(0, 3, "t2");

        // Write during READ_WAIT to the latched address: the read sees the new data
        write0(10'd9, 16'h0001);
        rd0   = 1'b1;
        addr0 = 10'd9;
        q0.push_back(16'hBEEF);
        @(negedge clk);
        wr0   = 1'b1;
        dout0 = 16'hBEEF;
        @(negedge clk);
        wr0 = 1'b0;
        wait_ready0(2, 3, "t3");

        // Write on the edge entering READ_DONE: the read returns the old data
        rd0   = 1'b1;
        addr0 = 10'd9;
        q0.push_back(16'hBEEF);
        @(negedge clk);
        @(negedge clk);
        wr0   = 1'b1;
        dout0 = 16'hCAFE;
        @(negedge clk);
        wr0 = 1'b0;
        wait_ready0(3, 3, "t3b");
        rd0   = 1'b1;
        q0.push_back(16'hCAFE);
        wait_ready0(0, 3, "t3c");

        // Read and write together in IDLE, then change the address mid-read
        write0(10'd8, 16'h8888);
        rd0   = 1'b1;
        wr0   = 1'b1;
        addr0 = 10'd7;
        dout0 = 16'h0F0F;
        q0.push_back(16'h0F0F);
        @(negedge clk);
        wr0   = 1'b0;
        addr0 = 10'd8;
        wait_ready0(1, 3, "t6");

        // Reset during READ_WAIT aborts the read; outputs clear asynchronously
        write0(10'd3, 16'h3333);
        rd0   = 1'b1;
        addr0 = 10'd3;
        @(negedge clk);
        check("t5_busy_before", {31'h0, busy0}, 32'h1);
        #2;
        resetN = 1'b0;
        #1;
        check("t5_rst_ready", {31'h0, rdy0}, 32'h0);
        check("t5_rst_busy", {31'h0, busy0}, 32'h0);
        check("t5_rst_data", {16'h0, din0}, 32'h0);
        rd0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        check("t5_no_ready", {31'h0, rdy0}, 32'h0);
        rd0   = 1'b1;
        addr0 = 10'd3;
        q0.push_back(16'h3333);
        wait_ready0(0, 3, "t5");

        // Latency-1 instance: held request, back-to-back reads every 2nd cycle
        @(negedge clk);
        wr1   = 1'b1;
        addr1 = 10'd0;
        dout1 = 16'hAAAA;
        @(negedge clk);
        addr1 = 10'd1;
        dout1 = 16'h5555;
        @(negedge clk);
        wr1   = 1'b0;
        rd1   = 1'b1;
        addr1 = 10'd0;
        q1.push_back(16'hAAAA);
        @(negedge clk);
        check("t4_ready1", {31'h0, rdy1}, 32'h1);
        addr1 = 10'd1;
        q1.push_back(16'h5555);
        @(negedge clk);
        check("t4_gap_ready", {31'h0, rdy1}, 32'h0);
        check("t4_gap_busy", {31'h0, busy1}, 32'h0);
        @(negedge clk);
        check("t4_ready2", {31'h0, rdy1}, 32'h1);
        rd1 = 1'b0;
        @(negedge clk);
        check("t4_after", {31'h0, rdy1}, 32'h0);

        @(negedge clk);
        @(negedge clk);
        check("q0_drained", q0.size(), 32'h0);
        check("q1_drained", q1.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
